store_write_buffer: RTL and testbench
=====================================

Name: store_write_buffer

Overview:
- Posted-write buffer between the MEM-stage store formatter and the data memory.
- Accepts one formatted store per cycle: word address, lane-aligned data and 4-bit byte enables, as produced by the store-type stage.
- Retires stores to memory in order, one per cycle, whenever the memory signals ready.
- Forwards buffered bytes to same-cycle loads, so loads see the newest store data before it drains.

Parameters:
- DEPTH, 4, number of buffer entries (power of two, ≥2).
- PTR_W, 2, log2(DEPTH), width of the read/write pointers.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- st_valid  input  1  store request from MEM stage this cycle
- st_addr  input  32  store byte address (bits [1:0] ignored; word-granular)
- st_data  input  32  lane-aligned store data
- st_be  input  4  byte enables (bit i ↔ data[8i+7:8i])
- st_stall  output  1  buffer full; MEM stage must hold the store
- ld_addr  input  32  load byte address for forwarding lookup (bits [1:0] ignored)
- fwd_data  output  32  forwarded bytes (lanes valid per fwd_mask, others 0)
- fwd_mask  output  4  per-byte hit mask from buffered stores
- mem_we  output  1  head entry valid, write request to DM
- mem_addr  output  32  {head word address, 2'b00}
- mem_wdata  output  32  head data
- mem_be  output  4  head byte enables
- mem_ready  input  1  DM accepts the write this cycle
- buf_empty  output  1  count == 0

Behaviour:
- Storage: DEPTH entries of {word_addr[29:0], data[31:0], be[3:0]}. Circular FIFO with wr_ptr, rd_ptr (PTR_W bits, wrap modulo DEPTH) and count (PTR_W+1 bits, 0..DEPTH).
- Reset (synchronous, on clk rising edge with reset=1):
  - count=0, wr_ptr=0, rd_ptr=0.
  - Entry contents need not be cleared but must never be observed.
  - The outputs below follow combinationally; they are 0/1 as stated immediately after reset.
- Reset mid-operation discards all pending stores; no mem_we is issued in the cycle after reset.
- push = st_valid && (st_be != 0) && (count != DEPTH).
  - st_valid with st_be == 0 is a no-op and stalls nothing.
- pop = mem_we && mem_ready.
- st_stall = st_valid && (count == DEPTH). Combinational, from registered count only.
  - A full buffer stalls even if pop occurs the same cycle; no push-on-full bypass.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together (count in 1..DEPTH-1): count unchanged, both pointers advance.
- Push writes the entry at wr_ptr with st_addr[31:2], st_data, st_be.
- Memory side:
  - mem_we = (count != 0).
  - mem_addr, mem_wdata, mem_be come from the entry at rd_ptr.
  - All three are forced to 0 when count == 0.
  - Outputs stay stable while mem_ready=0.
  - A store pushed into an empty buffer appears on mem_we the following cycle (1-cycle latency). No write-to-memory bypass.
- Forwarding (combinational):
  - Scan valid entries oldest to youngest, in rd_ptr order for count entries.
  - For each entry whose word_addr == ld_addr[31:2], every byte i with be[i]=1 sets fwd_mask[i]=1 and fwd_data[8i+7:8i] to that entry's byte. The youngest match wins per byte.
  - The store being pushed in the current cycle is NOT visible.
  - The entry being popped in the current cycle IS still visible.
  - No match gives fwd_mask=0, fwd_data=0.
- Ordering: memory sees stores in exact push order; no coalescing or reordering.
- buf_empty = (count == 0); buf_empty=1 after reset.

Test Plan:
- Reset, then push one store: addr=0x0000_0010, data=0x0000_00AB, be=0001, mem_ready=1.
  - Next cycle: mem_we=1, mem_addr=0x10, mem_wdata=0x0000_00AB, mem_be=0001.
  - Cycle after: buf_empty=1, mem_we=0.
- Fill to full with mem_ready=0: pushes to 0x0, 0x4, 0x8, 0xC (be=1111).
  - 5th st_valid gives st_stall=1; count stays 4; mem_addr holds 0x0.
  - Raise mem_ready: drains 0x0, 0x4, 0x8, 0xC on consecutive cycles.
- Byte-merge forwarding with mem_ready=0:
  - Push 0x20/0x1122_3344/be=1111, then 0x20/0x00AA_0000/be=0100.
  - ld_addr=0x22 gives fwd_mask=1111, fwd_data=0x11AA_3344.
  - ld_addr=0x24 gives fwd_mask=0000, fwd_data=0.
- Simultaneous push/pop at count=2 with mem_ready=1 for several cycles: count holds at 2, pointers wrap past DEPTH-1, and memory order equals push order.
- st_valid=1, st_be=0000 on an empty buffer: no entry, buf_empty stays 1, st_stall=0. Same stimulus on a full buffer: st_stall=1.
- Reset asserted with 3 entries pending and mem_ready=1: next cycle mem_we=0, buf_empty=1. The old entries are never written and never forwarded (fwd_mask=0 for their addresses).

Source files
------------

// File: rtl/store_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_write_buffer
// Purpose  : Posted-write buffer between the MEM-stage store formatter and the
//            data memory. Accepts one formatted store per cycle, drains stores
//            to memory in order, and forwards buffered bytes to loads.
// Revision : 1.0 - initial release
// ============================================================================
module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [3:0]  st_be,
  output logic        st_stall,
  input  logic [31:0] ld_addr,
  output logic [31:0] fwd_data,
  output logic [3:0]  fwd_mask,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  output logic        buf_empty
);

  localparam logic [PTR_W:0]   C_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] C_ONE  = PTR_W'(1);

  // Buffer storage and pointers
  logic [29:0]      ent_addr_q [DEPTH];
  logic [31:0]      ent_data_q [DEPTH];
  logic [3:0]       ent_be_q   [DEPTH];
  logic [29:0]      ent_addr_d [DEPTH];
  logic [31:0]      ent_data_d [DEPTH];
  logic [3:0]       ent_be_d   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;

  logic             push;
  logic             pop;
  logic             not_empty;
  logic [PTR_W-1:0] fwd_idx;

  // Byte-offset bits of both addresses are irrelevant: everything is word-granular.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

  // Handshake and status decode; stall looks only at the registered count so a
  // full buffer stalls even when the head drains in the same cycle.
  always_comb begin
    not_empty = (count_q != '0);
    push      = st_valid && (st_be != 4'b0000) && (count_q != C_FULL);
    mem_we    = not_empty;
    pop       = mem_we && mem_ready;
    st_stall  = st_valid && (count_q == C_FULL);
    buf_empty = !not_empty;
  end

  // Head entry drives the memory port; zeroed when nothing is buffered.
  always_comb begin
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_be    = 4'b0000;
    if (not_empty) begin
      mem_addr  = {ent_addr_q[rd_ptr_q], 2'b00};
      mem_wdata = ent_data_q[rd_ptr_q];
      mem_be    = ent_be_q[rd_ptr_q];
    end
  end

  // Next-state for pointers, occupancy and the entry written by a push.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    ent_be_d   = ent_be_q;

    if (push) begin
      ent_addr_d[wr_ptr_q] = st_addr[31:2];
      ent_data_d[wr_ptr_q] = st_data;
      ent_be_d[wr_ptr_q]   = st_be;
      wr_ptr_d             = wr_ptr_q + C_ONE;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + C_ONE;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards every pending store.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry payload; never cleared because count gates every observation of it.
  always_ff @(posedge clk) begin
    ent_addr_q <= ent_addr_d;
    ent_data_q <= ent_data_d;
    ent_be_q   <= ent_be_d;
  end

  // Load forwarding: walk valid entries oldest to youngest so younger bytes
  // overwrite older ones. The store arriving this cycle is not yet visible;
  // the head being popped this cycle still is.
  always_comb begin
    fwd_data = 32'h0;
    fwd_mask = 4'b0000;
    fwd_idx  = rd_ptr_q;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = rd_ptr_q + PTR_W'(k);
      if (((PTR_W+1)'(k) < count_q) && (ent_addr_q[fwd_idx] == ld_addr[31:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (ent_be_q[fwd_idx][b]) begin
            fwd_mask[b]       = 1'b1;
            fwd_data[8*b +: 8] = ent_data_q[fwd_idx][8*b +: 8];
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_write_buffer
// Purpose  : Scoreboard bench for store_write_buffer. Stimulus queues the
//            expected memory writes; a monitor pops and compares on every
//            accepted write. Status and forwarding outputs are checked inline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_write_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic        st_stall;
  logic [31:0] ld_addr;
  logic [31:0] fwd_data;
  logic [3:0]  fwd_mask;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic        buf_empty;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  store_write_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .st_valid  (st_valid),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_be     (st_be),
    .st_stall  (st_stall),
    .ld_addr   (ld_addr),
    .fwd_data  (fwd_data),
    .fwd_mask  (fwd_mask),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ready (mem_ready),
    .buf_empty (buf_empty)
  );

  always #5 clk = ~clk;

  // Monitor: every write the memory accepts must match the oldest expected one.
  always @(negedge clk) begin
    if (!reset && mem_we && mem_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL mem_write_unexpected: got addr=0x%08h data=0x%08h be=%b, required no write",
                 mem_addr, mem_wdata, mem_be);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data || mem_be !== e.be) begin
          n_err++;
          $display("FAIL mem_write: got addr=0x%08h data=0x%08h be=%b, required addr=0x%08h data=0x%08h be=%b",
                   mem_addr, mem_wdata, mem_be, e.addr, e.data, e.be);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive_st(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    st_valid = v;
    st_addr  = a;
    st_data  = d;
    st_be    = be;
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.be   = be;
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b0;
    ld_addr   = 32'h0;
    drive_st(1'b0, 32'h0, 32'h0, 4'b0000);
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    mid();
    chk("rst_buf_empty", 32'(buf_empty), 32'd1);
    chk("rst_mem_we",    32'(mem_we),    32'd0);
    chk("rst_mem_addr",  mem_addr,       32'h0);
    chk("rst_st_stall",  32'(st_stall),  32'd0);
    chk("rst_fwd_mask",  32'(fwd_mask),  32'd0);
    tick();

    // Single store, one-cycle latency to memory
    mem_ready = 1'b1;
    drive_st(1'b1, 32'h0000_0010, 32'h0000_00AB, 4'b0001);
    expect_wr(32'h0000_0010, 32'h0000_00AB, 4'b0001);
    mid();
    chk("single_no_bypass", 32'(mem_we), 32'd0);
    tick();
    drive_st(1'b0, 32'h0, 32'h0, 4'b0000);
    mid();
    chk("single_mem_we",    32'(mem_we), 32'd1);
    chk("single_mem_addr",  mem_addr,    32'h0000_0010);
    chk("single_mem_wdata", mem_wdata,   32'h0000_00AB);
    chk("single_mem_be",    32'(mem_be), 32'h1);
    tick();
    mid();
    chk("single_empty_after", 32'(buf_empty), 32'd1);
    chk("single_we_after",    32'(mem_we),    32'd0);
    tick();

    // Fill to full with memory stalled
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_st(1'b1, 32'(4*i), 32'hD000_0000 | 32'(i), 4'b1111);
      expect_wr(32'(4*i), 32'hD000_0000 | 32'(i), 4'b1111);
      tick();
    end
    drive_st(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'b1111);
    mid();
    chk("full_stall",    32'(st_stall), 32'd1);
    chk("full_mem_we",   32'(mem_we),   32'd1);
    chk("full_mem_addr", mem_addr,      32'h0);
    tick();
    drive_st(1'b1, 32'h0000_0044, 32'h0, 4'b0000);
    mid();
    chk("full_be0_stall", 32'(st_stall), 32'd1);
    chk("full_hold_addr", mem_addr,      32'h0);
    tick();
    drive_st(1'b0, 32'h0, 32'h0, 4'b0000);
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("drain_stall_low", 32'(st_stall), 32'd0);
      tick();
    end
    mid();
    chk("drain_empty", 32'(buf_empty), 32'd1);
    tick();

    // Byte-merge forwarding
    mem_ready = 1'b0;
    ld_addr   = 32'h0000_0020;
    drive_st(1'b1, 32'h0000_0020, 32'h1122_3344, 4'b1111);
    expect_wr(32'h0000_0020, 32'h1122_3344, 4'b1111);
    mid();
    chk("fwd_push_invisible", 32'(fwd_mask), 32'h0);
    tick();
    drive_st(1'b1, 32'h0000_0020, 32'h00AA_0000, 4'b0100);
    expect_wr(32'h0000_0020, 32'h00AA_0000, 4'b0100);
    tick();
    drive_st(1'b0, 32'h0, 32'h0, 4'b0000);
    ld_addr = 32'h0000_0022;
    mid();
    chk("fwd_merge_mask", 32'(fwd_mask), 32'hF);
    chk("fwd_merge_data", fwd_data,      32'h11AA_3344);
    tick();
    ld_addr = 32'h0000_0024;
    mid();
    chk("fwd_miss_mask", 32'(fwd_mask), 32'h0);
    chk("fwd_miss_data", fwd_data,      32'h0);
    tick();
    ld_addr   = 32'h0000_0020;
    mem_ready = 1'b1;
    mid();
    chk("fwd_pop_visible_mask", 32'(fwd_mask), 32'hF);
    chk("fwd_pop_visible_data", fwd_data,      32'h11AA_3344);
    tick();
    mid();
    chk("fwd_young_only_mask", 32'(fwd_mask), 32'h4);
    chk("fwd_young_only_data", fwd_data,      32'h00AA_0000);
    tick();
    mid();
    chk("fwd_drained_mask", 32'(fwd_mask), 32'h0);
    chk("fwd_drained_empty", 32'(buf_empty), 32'd1);
    tick();

    // Simultaneous push and pop at count 2, wrapping the pointers
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_st(1'b1, 32'h0000_0100 + 32'(4*i), 32'hC0DE_0000 | 32'(i), 4'b1111);
      expect_wr(32'h0000_0100 + 32'(4*i), 32'hC0DE_0000 | 32'(i), 4'b1111);
      tick();
    end
    mem_ready = 1'b1;
    for (int i = 2; i < 8; i++) begin
      drive_st(1'b1, 32'h0000_0100 + 32'(4*i), 32'hC0DE_0000 | 32'(i), 4'(i));
      expect_wr(32'h0000_0100 + 32'(4*i), 32'hC0DE_0000 | 32'(i), 4'(i));
      mid();
      chk("pp_not_empty", 32'(buf_empty), 32'd0);
      chk("pp_no_stall",  32'(st_stall),  32'd0);
      tick();
    end
    drive_st(1'b0, 32'h0, 32'h0, 4'b0000);
    mid();
    chk("pp_tail2_not_empty", 32'(buf_empty), 32'd0);
    tick();
    mid();
    chk("pp_tail1_not_empty", 32'(buf_empty), 32'd0);
    tick();
    mid();
    chk("pp_tail_empty", 32'(buf_empty), 32'd1);
    tick();

    // Zero byte-enable store on an empty buffer is a no-op
    drive_st(1'b1, 32'h0000_0300, 32'h5555_5555, 4'b0000);
    mid();
    chk("be0_no_stall", 32'(st_stall),  32'd0);
    chk("be0_empty",    32'(buf_empty), 32'd1);
    tick();
    drive_st(1'b0, 32'h0, 32'h0, 4'b0000);
    mid();
    chk("be0_still_empty", 32'(buf_empty), 32'd1);
    chk("be0_no_we",       32'(mem_we),    32'd0);
    tick();

    // Reset with three pending stores discards them
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_st(1'b1, 32'h0000_0200 + 32'(4*i), 32'hBAD0_0000 | 32'(i), 4'b1111);
      tick();
    end
    drive_st(1'b0, 32'h0, 32'h0, 4'b0000);
    reset     = 1'b1;
    mem_ready = 1'b1;
    tick();
    reset   = 1'b0;
    ld_addr = 32'h0000_0200;
    mid();
    chk("rstmid_mem_we",   32'(mem_we),    32'd0);
    chk("rstmid_empty",    32'(buf_empty), 32'd1);
    chk("rstmid_fwd_200",  32'(fwd_mask),  32'h0);
    tick();
    ld_addr = 32'h0000_0208;
    mid();
    chk("rstmid_fwd_208", 32'(fwd_mask), 32'h0);
    tick();
    ld_addr = 32'h0000_0204;
    mid();
    chk("rstmid_fwd_204", 32'(fwd_mask), 32'h0);
    tick();
    tick();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
